// File: rtl/booth_seq_accumulator.sv
// ---------------------------------------------------------------------------
// booth_seq_accumulator
//   Iterative radix-2 Booth multiplier stage. One multiplier bit pair
//   {Q[0], q_prev} is scanned per clock in RUN. Each scan adds 0, +M or -M
//   into a PWIDTH-bit signed accumulator. The shifted multiplicand M is
//   doubled after every step. Operands arrive on a valid/ready handshake.
//   The product leaves on a second valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   operand pair valid
//   in_ready   block can accept operands (IDLE only)
//   MCAND      signed multiplicand, WIDTH bits
//   MPLIER     signed multiplier, WIDTH bits
//   out_valid  PRODUCT valid (DONE)
//   out_ready  consumer accepts PRODUCT
//   PRODUCT    signed product MCAND*MPLIER, PWIDTH bits. It holds its value
//              after the output handshake and is cleared only by reset.
//   busy       high while in RUN
//
// Optional feature
//   BOOTH_EARLY_TERM_EN: RUN ends early once the remaining multiplier bits
//   are all equal to q_prev. In that case every remaining pair contributes
//   nothing. Without the macro, RUN always lasts WIDTH cycles.
// ---------------------------------------------------------------------------
module booth_seq_accumulator #(
  parameter int WIDTH  = 26,
  parameter int PWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  MCAND,
  input  logic [WIDTH-1:0]  MPLIER,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PWIDTH-1:0] PRODUCT,
  output logic              busy
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PWIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic                qprev_q, qprev_d;
  logic [SW-1:0]       step_q, step_d;
  logic [PWIDTH-1:0]   acc_q, acc_d;
  logic [PWIDTH-1:0]   product_q, product_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                finish;

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    q_d         = q_q;
    qprev_d     = qprev_q;
    step_d      = step_q;
    acc_d       = acc_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          m_d        = {{(PWIDTH-WIDTH){MCAND[WIDTH-1]}}, MCAND};
          q_d        = MPLIER;
          qprev_d    = 1'b0;
          acc_d      = '0;
          step_d     = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      RUN: begin
        case ({q_q[0], qprev_q})
          2'b01:   acc_d = acc_q + m_q;
          2'b10:   acc_d = acc_q - m_q;
          default: acc_d = acc_q;
        endcase
        m_d     = m_q << 1;
        qprev_d = q_q[0];
        q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_d  = step_q + 1'b1;

        finish = (step_q == LAST_STEP);
`ifdef BOOTH_EARLY_TERM_EN
        // The post-shift Q and q_prev are all equal, so every remaining pair
        // is 00 or 11 and the accumulator already holds the final product.
        if ((q_d == '0 && !qprev_d) || (q_d == '1 && qprev_d))
          finish = 1'b1;
`endif

        if (finish) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          product_d   = acc_d;
        end
      end

      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      q_q         <= '0;
      qprev_q     <= 1'b0;
      step_q      <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      q_q         <= q_d;
      qprev_q     <= qprev_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign PRODUCT   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_seq_accumulator.sv
module tb_booth_seq_accumulator;

  localparam int W  = 26;
  localparam int PW = 52;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  MCAND;
  logic [W-1:0]  MPLIER;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] PRODUCT;
  logic          busy;

  int n_vec  = 0;
  int n_fail = 0;

  booth_seq_accumulator #(.WIDTH(W), .PWIDTH(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MCAND     (MCAND),
    .MPLIER    (MPLIER),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .PRODUCT   (PRODUCT),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [PW-1:0] exp;
    int unsigned   stall;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles from accept to out_valid for a given multiplier.
  function automatic int exp_lat(input logic [W-1:0] mp);
    logic [W-1:0] q;
    logic         qp;
    q  = mp;
    qp = 1'b0;
    for (int s = 0; s < W; s++) begin
      qp = q[0];
      q  = {q[W-1], q[W-1:1]};
`ifdef BOOTH_EARLY_TERM_EN
      if ((q == '0 && !qp) || (q == '1 && qp)) return s + 1;
`endif
    end
    return W;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PW-1:0] exp, input int unsigned stall,
                       input string name);
    int cyc;
    logic [PW-1:0] held;
    cyc = 0;
    while (!in_ready && cyc < W + 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " in_ready_idle"}, in_ready, 1);
    MCAND     = a;
    MPLIER    = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    // keep junk valid during RUN/DONE; it must be ignored
    MCAND  = ~a;
    MPLIER = ~b;
    chk({name, " busy_run"}, busy, 1);
    chk({name, " in_ready_run"}, in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < W + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, PW'(cyc), PW'(exp_lat(b)));
    if (!out_valid) begin
      do_reset();
      return;
    end
    chk({name, " product"}, PRODUCT, exp);
    chk({name, " in_ready_done"}, in_ready, 0);
    held = PRODUCT;
    for (int i = 0; i < int'(stall); i++) begin
      @(posedge clk); #1;
      chk({name, " stall_valid"}, out_valid, 1);
      chk({name, " stall_hold"}, PRODUCT, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " post_valid"}, out_valid, 0);
    chk({name, " post_ready"}, in_ready, 1);
    chk({name, " post_busy"}, busy, 0);
    chk({name, " post_retain"}, PRODUCT, exp);
  endtask

  initial begin
    logic signed [W-1:0]  ra, rb;
    logic signed [PW-1:0] re;

    vecs[0] = '{26'd3,       26'd5,       52'd15,              0};
    vecs[1] = '{26'h3FFFFF9, 26'd6,       52'hFFFFFFFFFFFD6,   0};
    vecs[2] = '{26'h2000000, 26'h2000000, 52'h4000000000000,   10};
    vecs[3] = '{26'h1FFFFFF, 26'h1FFFFFF, 52'h3FFFFFC000001,   3};
    vecs[4] = '{26'd12345,   26'd0,       52'd0,               0};
    vecs[5] = '{26'd9,       26'd1,       52'd9,               0};
    vecs[6] = '{26'd5,       26'h3FFFFFF, 52'hFFFFFFFFFFFFB,   1};
    vecs[7] = '{26'h3FFFFFF, 26'h3FFFFFF, 52'd1,               2};
    vecs[8] = '{26'h2000000, 26'd1,       52'hFFFFFE000000 | 52'hF000000000000, 0};
    vecs[9] = '{26'h1FFFFFF, 26'h2000000, 52'hC000002000000,   1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    MCAND     = '0;
    MPLIER    = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset product", PRODUCT, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].mcand, vecs[i].mplier, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

    // Abort in RUN at step 12: no output, PRODUCT cleared
    MCAND    = 26'h1FFFFFF;
    MPLIER   = 26'h1FFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
    end
    chk("abort still busy", busy, 1);
    do_reset();
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort product", PRODUCT, 0);
    do_op(26'h1FFFFFF, 26'h1FFFFFF, 52'h3FFFFFC000001, 0, "after_abort");

    // Abort in DONE: no handshake, PRODUCT cleared
    MCAND    = 26'd7;
    MPLIER   = 26'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(posedge clk); #1;
    end
    chk("done_abort valid", out_valid, 1);
    do_reset();
    chk("done_abort out_valid", out_valid, 0);
    chk("done_abort product", PRODUCT, 0);

    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 50 == 0) ra = 26'h2000000;
      if (i % 70 == 0) rb = 26'h2000000;
      re = ra * rb;
      do_op(ra, rb, re, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/booth_seq_accumulator.md
Name: booth_seq_accumulator

Overview:
- Iterative radix-2 Booth multiplier stage. It sits directly downstream of the radix-2 Booth partial-product generator.
- Each cycle it scans one multiplier bit pair, forms that step's partial product (0, +M or −M, shifted) and accumulates it into a 2*WIDTH-bit signed sum.
- Operands are received and the product is delivered over valid/ready handshakes. It serves the 26-bit mantissa multiply path.

Parameters:
- WIDTH, 26, operand width (two's complement signed).
- PWIDTH, 2*WIDTH, product/accumulator width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- MCAND  input  WIDTH  multiplicand, signed.
- MPLIER  input  WIDTH  multiplier, signed.
- out_valid  output  1  PRODUCT valid.
- out_ready  input  1  consumer accepts PRODUCT.
- PRODUCT  output  PWIDTH  signed product MCAND*MPLIER.
- busy  output  1  high in RUN.

Behaviour:
- Reset: rst_n low at a rising edge →
  - state=IDLE; in_ready=1; out_valid=0; busy=0; PRODUCT=0.
  - Internal multiplicand, multiplier, q_prev, step counter and accumulator all cleared.
  - Reset mid-RUN or in DONE aborts the operation with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready →
    - Latch M=sign-extend(MCAND) to PWIDTH; Q=MPLIER; q_prev=0; acc=0; step=0.
    - Go to RUN.
  - RUN: in_ready=0, busy=1. Each edge:
    - pair={Q[0],q_prev}. 00/11: acc unchanged. 01: acc+=M. 10: acc−=M (two's complement, modulo 2^PWIDTH).
    - Then M<<=1, q_prev=Q[0], Q arithmetic-shift-right by 1, step++.
    - After the edge where step reaches WIDTH−1 (the WIDTH-th processing edge), go to DONE.
  - DONE: out_valid=1, PRODUCT=acc, held stable while out_ready=0. On out_valid&&out_ready → IDLE, out_valid=0.
- Latency:
  - out_valid rises exactly WIDTH cycles after the accepting edge (26 for default).
  - Throughput is one product per WIDTH+2 cycles minimum.
- in_ready is low in RUN and DONE. in_valid asserted there is ignored and does not need to be held off by the producer's logic. There is no accept-and-deliver overlap in DONE.
- Arithmetic:
  - Result is the exact signed product; no overflow is possible in PWIDTH.
  - Includes MCAND=MPLIER=−2^(WIDTH−1) → +2^(2*WIDTH−2).
- PRODUCT retains its last value in IDLE after a handshake; it is cleared only by reset.
- Simultaneous out_ready with out_valid=0 has no effect.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined:
  - In RUN, after each edge's update, evaluate the post-shift state.
  - If (Q==0 && q_prev==0) or (Q==all-ones && q_prev==1), every remaining pair contributes nothing, so go to DONE immediately.
  - The WIDTH-step limit still applies.
  - Latency is variable, 1..WIDTH cycles; the result is identical.
- Undefined: fixed WIDTH-cycle RUN; no termination logic is synthesised.

Test Plan:
- Basic multiply: MCAND=3, MPLIER=5, out_ready=1 → out_valid exactly 26 cycles after accept; PRODUCT=15; in_ready=1 the cycle after the output handshake.
- Signed operands: MCAND=−7, MPLIER=6 → PRODUCT=0xFFFFFFFFFFFD6 (−42). Then MCAND=0x2000000 (−2^25), MPLIER=0x2000000 → PRODUCT=0x4000000000000.
- Backpressure:
  - out_ready=0 for 10 cycles after out_valid → PRODUCT and out_valid held stable.
  - in_valid pulses during RUN/DONE are ignored.
  - Release → one handshake, then IDLE.
- Reset mid-operation: rst_n low at RUN step 12 → next cycle in_ready=1, out_valid=0, PRODUCT=0. A following 0x1FFFFFF*0x1FFFFFF yields 0x3FFFFFC000001.
- Randomized cross-check: 500 random signed pairs with random out_ready stalls → every PRODUCT equals the reference signed product, in order.
- Early termination (with BOOTH_EARLY_TERM_EN):
  - MPLIER=0 → DONE after 1 cycle, PRODUCT=0.
  - MCAND=9, MPLIER=1 → DONE after 2 cycles, PRODUCT=9.
  - MPLIER=−1 → PRODUCT=−MCAND after 1 cycle.
  - Without the macro, each of these takes 26 cycles with the same PRODUCT.
